// File: rtl/bp_clint_mc.sv
// Multi-core core-local interruptor: per-core msip and mtimecmp plus one shared
// prescaled 64-bit mtime, served over a single-outstanding command/response port.
module bp_clint_mc #(
  parameter int unsigned             num_core_p   = 1,
  parameter int unsigned             addr_width_p = 40,
  parameter logic [addr_width_p-1:0] base_addr_p  = addr_width_p'(32'h0200_0000),
  parameter int unsigned             mtime_div_p  = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_w_i,
  input  logic [addr_width_p-1:0] cmd_addr_i,
  input  logic [1:0]              cmd_size_i,
  input  logic [63:0]             cmd_data_i,
  output logic                    resp_v_o,
  output logic [63:0]             resp_data_o,
  output logic                    resp_err_o,
  input  logic                    resp_yumi_i,
  output logic [num_core_p-1:0]   software_irq_o,
  output logic [num_core_p-1:0]   timer_irq_o
);

  localparam int unsigned idx_width_lp = 12;
  localparam int unsigned div_width_lp = (mtime_div_p > 1) ? $clog2(mtime_div_p) : 1;
  localparam logic [div_width_lp-1:0] div_last_lp = div_width_lp'(mtime_div_p - 1);

  typedef enum logic {
    e_idle = 1'b0,
    e_resp = 1'b1
  } state_e;

  state_e state_q, state_n;

  logic [num_core_p-1:0]   msip_q;
  logic [63:0]             mtimecmp_q [num_core_p];
  logic [63:0]             mtime_q;
  logic [div_width_lp-1:0] div_cnt_q;
  logic [63:0]             resp_data_q;
  logic                    resp_err_q;
  logic [num_core_p-1:0]   timer_irq_q;

  logic [15:0]             off;
  logic [idx_width_lp-1:0] msip_idx;
  logic [idx_width_lp-1:0] cmp_idx;
  logic                    hit;
  logic                    is8;
  logic                    hi_half;
  logic                    size_ok;
  logic                    align_ok;
  logic                    msip_sel;
  logic                    cmp_sel;
  logic                    mtime_sel;
  logic                    dec_err;
  logic [63:0]             rd_data;
  logic                    handshake;
  logic                    wr;
  logic                    tick;

  // 4 B accesses see one 32-bit half, zero-extended.
  function automatic logic [63:0] sel_half(input logic [63:0] v, input logic full,
                                           input logic hi);
    if (full) return v;
    return hi ? {32'd0, v[63:32]} : {32'd0, v[31:0]};
  endfunction

  // 4 B stores replace one half and leave the other half as currently held.
  function automatic logic [63:0] merge_half(input logic [63:0] old, input logic [63:0] data,
                                             input logic full, input logic hi);
    if (full) return data;
    return hi ? {data[31:0], old[31:0]} : {old[63:32], data[31:0]};
  endfunction

  // Address decode, error classification and pre-update read mux.
  always_comb begin
    off       = cmd_addr_i[15:0];
    hit       = (cmd_addr_i[addr_width_p-1:16] == base_addr_p[addr_width_p-1:16]);
    is8       = (cmd_size_i == 2'd3);
    hi_half   = off[2];
    size_ok   = (cmd_size_i == 2'd2) || is8;
    align_ok  = is8 ? (off[2:0] == 3'd0) : (off[1:0] == 2'd0);
    msip_idx  = off[13:2];
    cmp_idx   = idx_width_lp'((off - 16'h4000) >> 3);
    msip_sel  = (off < 16'h4000) && !is8 && (32'(msip_idx) < num_core_p);
    cmp_sel   = (off >= 16'h4000) && (off < 16'hbff8) && (32'(cmp_idx) < num_core_p);
    mtime_sel = (off[15:3] == 13'h17ff);
    dec_err   = !hit || !size_ok || !align_ok || !(msip_sel || cmp_sel || mtime_sel);

    rd_data = '0;
    for (int unsigned i = 0; i < num_core_p; i++) begin
      if (msip_sel && (msip_idx == idx_width_lp'(i))) rd_data = {63'd0, msip_q[i]};
      if (cmp_sel && (cmp_idx == idx_width_lp'(i)))  rd_data = sel_half(mtimecmp_q[i], is8, hi_half);
    end
    if (mtime_sel) rd_data = sel_half(mtime_q, is8, hi_half);
  end

  // Two-state command FSM.
  always_comb begin
    state_n   = state_q;
    handshake = 1'b0;
    case (state_q)
      e_idle: begin
        if (cmd_v_i) begin
          handshake = 1'b1;
          state_n   = e_resp;
        end
      end
      e_resp: begin
        if (resp_yumi_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  assign wr   = handshake && cmd_w_i && !dec_err;
  assign tick = (div_cnt_q == div_last_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= e_idle;
    else            state_q <= state_n;
  end

  // Response payload captured at the handshake edge.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else if (handshake) begin
      resp_err_q  <= dec_err;
      resp_data_q <= (dec_err || cmd_w_i) ? 64'd0 : rd_data;
    end
  end

  // Prescaler and mtime; a store beats a same-cycle tick and leaves the prescaler running.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      div_cnt_q <= '0;
      mtime_q   <= '0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + div_width_lp'(1);
      if (wr && mtime_sel) mtime_q <= merge_half(mtime_q, cmd_data_i, is8, hi_half);
      else if (tick)       mtime_q <= mtime_q + 64'd1;
    end
  end

  // Per-core msip, mtimecmp and registered timer compare.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      msip_q      <= '0;
      timer_irq_q <= '0;
      for (int unsigned i = 0; i < num_core_p; i++) mtimecmp_q[i] <= '1;
    end else begin
      for (int unsigned i = 0; i < num_core_p; i++) begin
        timer_irq_q[i] <= (mtime_q >= mtimecmp_q[i]);
        if (wr && msip_sel && (msip_idx == idx_width_lp'(i))) msip_q[i] <= cmd_data_i[0];
        if (wr && cmp_sel && (cmp_idx == idx_width_lp'(i)))
          mtimecmp_q[i] <= merge_half(mtimecmp_q[i], cmd_data_i, is8, hi_half);
      end
    end
  end

  assign cmd_ready_o    = (state_q == e_idle);
  assign resp_v_o       = (state_q == e_resp);
  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;
  assign software_irq_o = msip_q;
  assign timer_irq_o    = timer_irq_q;

endmodule

// File: tb/tb_bp_clint_mc.sv
// Directed bench for bp_clint_mc: a 4-core divide-by-1 instance plus a 1-core
// divide-by-3 instance sharing the same command stream.
module tb_bp_clint_mc;

  localparam logic [39:0] base_c = 40'h00_0200_0000;

  logic        clk;
  logic        reset_n;
  logic        cmd_v;
  logic        cmd_w;
  logic [39:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [63:0] cmd_data;
  logic        resp_yumi;

  logic        cmd_ready, resp_v, resp_err;
  logic [63:0] resp_data;
  logic [3:0]  sw_irq, tmr_irq;

  logic        cmd_ready3, resp_v3, resp_err3;
  logic [63:0] resp_data3;
  logic [0:0]  sw_irq3, tmr_irq3;

  logic        r_v, r_err;
  logic [63:0] r_data, r_data3;
  logic [3:0]  r_sw;

  int checks = 0;
  int errors = 0;

  bp_clint_mc #(
    .num_core_p(4), .addr_width_p(40), .base_addr_p(base_c), .mtime_div_p(1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_w_i(cmd_w), .cmd_addr_i(cmd_addr),
    .cmd_size_i(cmd_size), .cmd_data_i(cmd_data),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_err_o(resp_err), .resp_yumi_i(resp_yumi),
    .software_irq_o(sw_irq), .timer_irq_o(tmr_irq)
  );

  bp_clint_mc #(
    .num_core_p(1), .addr_width_p(40), .base_addr_p(base_c), .mtime_div_p(3)
  ) dut3 (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready3), .cmd_w_i(cmd_w), .cmd_addr_i(cmd_addr),
    .cmd_size_i(cmd_size), .cmd_data_i(cmd_data),
    .resp_v_o(resp_v3), .resp_data_o(resp_data3), .resp_err_o(resp_err3), .resp_yumi_i(resp_yumi),
    .software_irq_o(sw_irq3), .timer_irq_o(tmr_irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset for two edges, release at a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a falling edge; handshake at the next rising edge, yumi in the first RESP cycle.
  task automatic issue(input logic w, input logic [39:0] addr, input logic [1:0] size,
                       input logic [63:0] data);
    cmd_v = 1'b1; cmd_w = w; cmd_addr = addr; cmd_size = size; cmd_data = data;
    @(negedge clk);
    cmd_v   = 1'b0;
    r_v     = resp_v;
    r_err   = resp_err;
    r_data  = resp_data;
    r_data3 = resp_data3;
    r_sw    = sw_irq;
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic [63:0] exp_data, input logic exp_err);
    check({tag, "_v_err"}, 64'({r_v, r_err}), 64'({1'b1, exp_err}));
    check({tag, "_data"}, r_data, exp_data);
  endtask

  initial begin
    cmd_v = 1'b0; cmd_w = 1'b0; cmd_addr = '0; cmd_size = 2'd0; cmd_data = '0;
    resp_yumi = 1'b0; reset_n = 1'b0;
    @(negedge clk);

    // Reset state and free-running mtime
    do_reset();
    check("rst_ctl", 64'({cmd_ready, resp_v, resp_err}), 64'(3'b100));
    check("rst_data", resp_data, 64'd0);
    check("rst_irq", 64'({sw_irq, tmr_irq}), 64'd0);
    check("rst_dut3", 64'({cmd_ready3, resp_v3, resp_err3, sw_irq3, tmr_irq3}), 64'(5'b10000));
    repeat (3) @(negedge clk);
    issue(1'b0, base_c + 40'hbff8, 2'd3, 64'd0);
    expect_resp("mtime_free", 64'd3, 1'b0);
    check("mtime_div3", r_data3, 64'd1);
    check("irq_quiet", 64'({sw_irq, tmr_irq}), 64'd0);

    // msip
    do_reset();
    issue(1'b1, base_c + 40'h8, 2'd2, 64'd1);
    expect_resp("msip2_set", 64'd0, 1'b0);
    check("msip2_irq", 64'(r_sw), 64'(4'b0100));
    issue(1'b0, base_c + 40'h8, 2'd2, 64'd0);
    expect_resp("msip2_rd1", 64'd1, 1'b0);
    issue(1'b1, base_c + 40'h8, 2'd2, 64'd2);
    check("msip2_clr_irq", 64'(r_sw), 64'd0);
    issue(1'b0, base_c + 40'h8, 2'd2, 64'd0);
    expect_resp("msip2_rd0", 64'd0, 1'b0);
    issue(1'b1, base_c + 40'h0, 2'd2, 64'hffff_ffff);
    check("msip0_irq", 64'(r_sw), 64'(4'b0001));
    issue(1'b0, base_c + 40'h0, 2'd2, 64'd0);
    expect_resp("msip0_rd", 64'd1, 1'b0);

    // mtimecmp and timer compare
    do_reset();
    issue(1'b1, base_c + 40'h4008, 2'd3, 64'd100);
    expect_resp("cmp1_wr", 64'd0, 1'b0);
    issue(1'b0, base_c + 40'h4008, 2'd3, 64'd0);
    expect_resp("cmp1_rd", 64'd100, 1'b0);
    issue(1'b0, base_c + 40'h4000, 2'd3, 64'd0);
    expect_resp("cmp0_rd", 64'hffff_ffff_ffff_ffff, 1'b0);
    issue(1'b0, base_c + 40'h400c, 2'd2, 64'd0);
    expect_resp("cmp1_hi_rd", 64'd0, 1'b0);
    repeat (92) @(negedge clk);
    check("tmr_before", 64'(tmr_irq), 64'd0);
    @(negedge clk);
    check("tmr_rise", 64'(tmr_irq), 64'(4'b0010));
    issue(1'b1, base_c + 40'h400c, 2'd2, 64'd5);
    check("tmr_fall", 64'(tmr_irq), 64'd0);
    issue(1'b0, base_c + 40'h4008, 2'd3, 64'd0);
    expect_resp("cmp1_merge", 64'h0000_0005_0000_0064, 1'b0);

    // mtime half stores and wrap
    do_reset();
    issue(1'b1, base_c + 40'hbff8, 2'd2, 64'hffff_ffff);
    expect_resp("mt_lo_wr", 64'd0, 1'b0);
    issue(1'b0, base_c + 40'hbff8, 2'd3, 64'd0);
    expect_resp("mt_carry", 64'h0000_0001_0000_0000, 1'b0);
    check("mt3_lo", r_data3, 64'h0000_0000_ffff_ffff);
    issue(1'b1, base_c + 40'hbffc, 2'd2, 64'd0);
    expect_resp("mt_hi_wr", 64'd0, 1'b0);
    issue(1'b0, base_c + 40'hbff8, 2'd3, 64'd0);
    expect_resp("mt_hi_nocarry", 64'd3, 1'b0);
    check("mt3_presc", r_data3, 64'd1);
    issue(1'b0, base_c + 40'hbff8, 2'd2, 64'd0);
    expect_resp("mt_lo_rd", 64'd5, 1'b0);
    issue(1'b1, base_c + 40'hbff8, 2'd3, 64'hffff_ffff_ffff_ffff);
    check("tmr_all_max", 64'(tmr_irq), 64'(4'b1111));
    issue(1'b0, base_c + 40'hbff8, 2'd3, 64'd0);
    expect_resp("mt_wrap", 64'd0, 1'b0);
    check("tmr_after_wrap", 64'(tmr_irq), 64'd0);

    // Error cases
    do_reset();
    issue(1'b0, base_c + 40'h4004, 2'd3, 64'd0);
    expect_resp("err_mis8", 64'd0, 1'b1);
    issue(1'b1, base_c + 40'h8, 2'd1, 64'd1);
    expect_resp("err_size", 64'd0, 1'b1);
    check("err_size_irq", 64'(r_sw), 64'd0);
    issue(1'b1, base_c + 40'h10, 2'd2, 64'd1);
    expect_resp("err_msip4", 64'd0, 1'b1);
    check("err_msip4_irq", 64'(r_sw), 64'd0);
    issue(1'b0, base_c + 40'h1_0000, 2'd3, 64'd0);
    expect_resp("err_miss", 64'd0, 1'b1);
    issue(1'b1, base_c + 40'h0, 2'd3, 64'd1);
    expect_resp("err_msip8", 64'd0, 1'b1);
    check("err_msip8_irq", 64'(r_sw), 64'd0);
    issue(1'b1, base_c + 40'h4004, 2'd3, 64'd0);
    expect_resp("err_cmp_mis", 64'd0, 1'b1);
    issue(1'b1, base_c + 40'h4020, 2'd3, 64'd0);
    expect_resp("err_cmp4", 64'd0, 1'b1);
    issue(1'b0, base_c + 40'hbffa, 2'd2, 64'd0);
    expect_resp("err_mt_mis", 64'd0, 1'b1);
    issue(1'b0, base_c + 40'h4000, 2'd3, 64'd0);
    expect_resp("err_cmp0_kept", 64'hffff_ffff_ffff_ffff, 1'b0);
    issue(1'b0, base_c + 40'h4018, 2'd2, 64'd0);
    expect_resp("err_cmp3_lo", 64'h0000_0000_ffff_ffff, 1'b0);
    check("err_tmr", 64'(tmr_irq), 64'd0);

    // Response stall and reset during RESP
    do_reset();
    issue(1'b1, base_c + 40'h0, 2'd2, 64'd1);
    issue(1'b1, base_c + 40'h4000, 2'd3, 64'd0);
    check("stall_pre_irq", 64'({sw_irq, tmr_irq}), 64'({4'b0001, 4'b0001}));
    cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = base_c + 40'hbff8; cmd_size = 2'd3; cmd_data = '0;
    @(negedge clk);
    cmd_v = 1'b0;
    check("stall_ctl0", 64'({cmd_ready, resp_v, resp_err}), 64'(3'b010));
    check("stall_data0", resp_data, 64'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_ctl", 64'({cmd_ready, resp_v, resp_err}), 64'(3'b010));
      check("stall_data", resp_data, 64'd4);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_ctl", 64'({cmd_ready, resp_v, resp_err}), 64'(3'b100));
    check("midrst_data", resp_data, 64'd0);
    check("midrst_irq", 64'({sw_irq, tmr_irq}), 64'd0);
    reset_n = 1'b1;
    issue(1'b0, base_c + 40'h4000, 2'd3, 64'd0);
    expect_resp("midrst_cmp0", 64'hffff_ffff_ffff_ffff, 1'b0);
    issue(1'b0, base_c + 40'h0, 2'd2, 64'd0);
    expect_resp("midrst_msip0", 64'd0, 1'b0);
    issue(1'b0, base_c + 40'hbff8, 2'd3, 64'd0);
    expect_resp("midrst_mtime", 64'd4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
